// File: rtl/spi_cpu_pkg.sv
// Shared SPI fetch definitions: READ opcode, address width and fetch FSM states.
// Burst builds (SPI_FETCH_BURST_EN) add the HOLD state.
package spi_cpu_pkg;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;
  localparam int SPI_ADDR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DONE,
    ST_GAP
`ifdef SPI_FETCH_BURST_EN
    , ST_HOLD
`endif
  } fetch_state_t;

  // Full 32-bit serial frame: opcode, address, then 8 don't-care bits for the data phase.
  function automatic logic [31:0] read_frame(input logic [SPI_ADDR_W-1:0] addr);
    return {SPI_CMD_READ, addr, 8'h00};
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// Mode-0 SCK generator: CLK_DIV clk cycles per half-period, low phase first.
// rise/fall strobes are high on the cycle whose closing clk edge changes sck.
module spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam logic [3:0] HALF_LAST = 4'(CLK_DIV - 1);

  logic [3:0] cnt_reg;
  logic       sck_reg;
  logic       wrap;

  assign wrap = en && !start && (cnt_reg == HALF_LAST);
  assign rise = wrap && !sck_reg;
  assign fall = wrap && sck_reg;
  assign sck  = sck_reg;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      cnt_reg <= 4'd0;
      sck_reg <= 1'b0;
    end else if (en) begin
      if (cnt_reg == HALF_LAST) begin
        cnt_reg <= 4'd0;
        sck_reg <= ~sck_reg;
      end else begin
        cnt_reg <= cnt_reg + 4'd1;
      end
    end
  end

endmodule

// File: rtl/spi_fetch_master.sv
// Instruction-byte fetcher: READ (0x03) + 16-bit address + 1 data byte over SPI mode 0.
// Define SPI_FETCH_BURST_EN to keep cs_n low after a fetch and stream sequential bytes.
module spi_fetch_master
  import spi_cpu_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [SPI_ADDR_W-1:0] fetch_addr,
  output logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [7:0]            fetch_data,
  output logic                  spi_cs_n,
  output logic                  spi_sck,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam logic [3:0] GAP_LAST = 4'(CS_GAP - 1);

  fetch_state_t state_reg;
  logic [31:0]  shift_reg;
  logic [4:0]   bit_cnt_reg;
  logic [3:0]   gap_cnt_reg;
  logic         cs_n_reg;
  logic         mosi_reg;
  logic         valid_reg;
  logic [7:0]   data_reg;
  logic         ready_reg;

  logic sck_start, sck_en, sck_rise, sck_fall;

  assign sck_en = (state_reg == ST_CMD) || (state_reg == ST_ADDR) || (state_reg == ST_DATA);

`ifdef SPI_FETCH_BURST_EN
  logic [SPI_ADDR_W-1:0] last_addr_reg;
  logic                  hold_seq;
  logic                  gap_launch;

  assign hold_seq   = (state_reg == ST_HOLD) && fetch_req &&
                      (last_addr_reg != 16'hFFFF) && (fetch_addr == last_addr_reg + 16'd1);
  assign gap_launch = (state_reg == ST_GAP) && (gap_cnt_reg == 4'd0);
  assign sck_start  = ((state_reg == ST_IDLE) && fetch_req) || hold_seq || gap_launch;
`else
  assign sck_start  = (state_reg == ST_IDLE) && fetch_req;
`endif

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk   (clk),
    .rst   (rst),
    .start (sck_start),
    .en    (sck_en),
    .sck   (spi_sck),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= 32'd0;
      bit_cnt_reg <= 5'd0;
      gap_cnt_reg <= 4'd0;
      cs_n_reg    <= 1'b1;
      mosi_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      data_reg    <= 8'h00;
      ready_reg   <= 1'b1;
`ifdef SPI_FETCH_BURST_EN
      last_addr_reg <= '0;
`endif
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (fetch_req) begin
            shift_reg   <= read_frame(fetch_addr);
            mosi_reg    <= SPI_CMD_READ[7];
            cs_n_reg    <= 1'b0;
            ready_reg   <= 1'b0;
            bit_cnt_reg <= 5'd0;
            state_reg   <= ST_CMD;
`ifdef SPI_FETCH_BURST_EN
            last_addr_reg <= fetch_addr;
`endif
          end
        end
        ST_CMD, ST_ADDR, ST_DATA: begin
          // MISO shifts in at every rise; only the last 8 samples matter.
          if (sck_rise)
            shift_reg <= {shift_reg[30:0], spi_miso};
          if (sck_fall) begin
            bit_cnt_reg <= bit_cnt_reg + 5'd1;
            mosi_reg    <= (bit_cnt_reg < 5'd23) ? shift_reg[31] : 1'b0;
            if (bit_cnt_reg == 5'd7)
              state_reg <= ST_ADDR;
            if (bit_cnt_reg == 5'd23)
              state_reg <= ST_DATA;
            if (bit_cnt_reg == 5'd31) begin
              state_reg <= ST_DONE;
              valid_reg <= 1'b1;
              data_reg  <= shift_reg[7:0];
            end
          end
        end
        ST_DONE: begin
`ifdef SPI_FETCH_BURST_EN
          state_reg <= ST_HOLD;
          ready_reg <= 1'b1;
`else
          state_reg   <= ST_GAP;
          cs_n_reg    <= 1'b1;
          gap_cnt_reg <= GAP_LAST;
`endif
        end
        ST_GAP: begin
          if (gap_cnt_reg == 4'd0) begin
`ifdef SPI_FETCH_BURST_EN
            // GAP is only reached from a non-sequential HOLD request; replay it in full.
            shift_reg   <= read_frame(last_addr_reg);
            mosi_reg    <= SPI_CMD_READ[7];
            cs_n_reg    <= 1'b0;
            bit_cnt_reg <= 5'd0;
            state_reg   <= ST_CMD;
`else
            state_reg <= ST_IDLE;
            ready_reg <= 1'b1;
`endif
          end else begin
            gap_cnt_reg <= gap_cnt_reg - 4'd1;
          end
        end
`ifdef SPI_FETCH_BURST_EN
        ST_HOLD: begin
          if (fetch_req) begin
            ready_reg     <= 1'b0;
            last_addr_reg <= fetch_addr;
            if (hold_seq) begin
              state_reg   <= ST_DATA;
              bit_cnt_reg <= 5'd24;
              mosi_reg    <= 1'b0;
            end else begin
              state_reg   <= ST_GAP;
              cs_n_reg    <= 1'b1;
              gap_cnt_reg <= GAP_LAST;
            end
          end
        end
`endif
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign fetch_ready = ready_reg;
  assign fetch_valid = valid_reg;
  assign fetch_data  = data_reg;
  assign spi_cs_n    = cs_n_reg;
  assign spi_mosi    = mosi_reg;

endmodule
